cr_xp10_decomp_htf_bl_ctrl: RTL and testbench

Sequencer for the Huffman bit-length count array (per-length counter bank with preload and NUM_PORTS one-hot increment ports).
- Clears the array, then converts incoming symbol code-length streams into one-hot increments.
- After the last symbol it walks the settled counts to produce canonical first-code values per length and tree-validity status.
- Sits between the XP10 header/length parser and the Huffman decode-table builder.

---
 rtl/cr_xp10_decomp_htf_bl_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cr_xp10_decomp_htf_bl_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_xp10_decomp_htf_bl_ctrl.sv
// Huffman bit-length count sequencer: clears the count array, turns symbol lengths into
// one-hot increments, then scans counts into canonical first codes. Option: CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN.
module cr_xp10_decomp_htf_bl_ctrl #(
    parameter int unsigned DEPTH     = 27,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned LEN_W     = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [NUM_PORTS-1:0]                sym_valid,
    input  logic [NUM_PORTS-1:0][LEN_W-1:0]     sym_len,
    input  logic                                sym_last,
    output logic                                sym_ready,
    output logic [DEPTH:1]                      arr_preload_en,
    output logic [WIDTH-1:0]                    arr_preload_data,
    output logic [NUM_PORTS-1:0][DEPTH:1]       arr_inc_onehot,
    input  logic [DEPTH:1][WIDTH-1:0]           arr_count,
    output logic                                fc_valid,
    output logic [LEN_W-1:0]                    fc_len,
    output logic [DEPTH-1:0]                    fc_code,
    output logic [WIDTH-1:0]                    fc_count,
    output logic                                done,
    output logic                                oversub,
    output logic                                incomplete,
    output logic                                len_err
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
   ,output logic [LEN_W-1:0]                    max_len_o
`endif
);

    localparam int unsigned SW = DEPTH + 2;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, SCAN, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  k;
    logic [DEPTH:0]    code;
    logic              os_acc;
    logic              nz_acc;

    logic              beat_err;
    logic [LEN_W-1:0]  last_k;
    logic [LEN_W-1:0]  k_rd;
    logic [LEN_W-1:0]  k_nx;
    logic [LEN_W-1:0]  k_nx_rd;
    logic [WIDTH-1:0]  cnt_k;
    logic [WIDTH-1:0]  cnt_nx;
    logic [SW-1:0]     sum;
    logic [SW-1:0]     pow2_k;
    logic [DEPTH:0]    code_nx;
    logic              os_now;
    logic              nz_now;

`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
    logic [LEN_W-1:0]  max_len;
    logic [LEN_W-1:0]  beat_max;
    assign max_len_o = max_len;
    assign last_k    = max_len;
`else
    assign last_k    = LEN_W'(DEPTH);
`endif

    assign sym_ready        = (state == ACCUM);
    assign arr_preload_en   = {DEPTH{state == CLEAR}};
    assign arr_preload_data = '0;

    always_comb begin
        arr_inc_onehot = '0;
        beat_err       = 1'b0;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
        beat_max       = '0;
`endif
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (state == ACCUM && sym_valid[p]) begin
                if (sym_len[p] > LEN_W'(DEPTH))
                    beat_err = 1'b1;
                for (int unsigned d = 1; d <= DEPTH; d++)
                    arr_inc_onehot[p][d] = (sym_len[p] == LEN_W'(d));
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
                if (sym_len[p] <= LEN_W'(DEPTH) && sym_len[p] > beat_max)
                    beat_max = sym_len[p];
`endif
            end
        end
    end

    // k is only meaningful in SCAN; clamp the read index so idle cycles stay in range
    always_comb begin
        k_rd    = (k >= LEN_W'(1) && k <= LEN_W'(DEPTH)) ? k : LEN_W'(1);
        k_nx    = k + LEN_W'(1);
        k_nx_rd = (k_nx >= LEN_W'(1) && k_nx <= LEN_W'(DEPTH)) ? k_nx : LEN_W'(1);
        cnt_k   = arr_count[k_rd];
        cnt_nx  = arr_count[k_nx_rd];
        sum     = {1'b0, code} + SW'(cnt_k);
        pow2_k  = SW'(1) << k;
        code_nx = {sum[DEPTH-1:0], 1'b0};
        os_now  = os_acc | (sum > pow2_k);
        nz_now  = nz_acc | (cnt_k != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            code       <= '0;
            os_acc     <= 1'b0;
            nz_acc     <= 1'b0;
            fc_valid   <= 1'b0;
            fc_len     <= '0;
            fc_code    <= '0;
            fc_count   <= '0;
            done       <= 1'b0;
            oversub    <= 1'b0;
            incomplete <= 1'b0;
            len_err    <= 1'b0;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
            max_len    <= '0;
`endif
        end else if (start) begin
            state      <= CLEAR;
            k          <= '0;
            fc_valid   <= 1'b0;
            fc_len     <= '0;
            fc_code    <= '0;
            fc_count   <= '0;
            done       <= 1'b0;
            oversub    <= 1'b0;
            incomplete <= 1'b0;
            len_err    <= 1'b0;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
            max_len    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: ;
                CLEAR: state <= ACCUM;
                ACCUM: begin
                    if (beat_err)
                        len_err <= 1'b1;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
                    if (beat_max > max_len)
                        max_len <= beat_max;
`endif
                    if (|sym_valid && sym_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    k      <= LEN_W'(1);
                    code   <= '0;
                    os_acc <= 1'b0;
                    nz_acc <= 1'b0;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
                    if (max_len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        state    <= SCAN;
                        fc_valid <= 1'b1;
                        fc_len   <= LEN_W'(1);
                        fc_code  <= '0;
                        fc_count <= arr_count[1];
                    end
                end
                SCAN: begin
                    os_acc <= os_now;
                    nz_acc <= nz_now;
                    if (k == last_k) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        oversub    <= os_now;
                        incomplete <= !os_now && nz_now && (sum < pow2_k);
                        fc_valid   <= 1'b0;
                        fc_len     <= '0;
                        fc_code    <= '0;
                        fc_count   <= '0;
                    end else begin
                        k        <= k_nx;
                        code     <= code_nx;
                        fc_len   <= k_nx;
                        fc_code  <= code_nx[DEPTH-1:0];
                        fc_count <= cnt_nx;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_xp10_decomp_htf_bl_ctrl.sv
// Directed bench for cr_xp10_decomp_htf_bl_ctrl with a behavioural count-array model.
module tb_cr_xp10_decomp_htf_bl_ctrl;

    localparam int unsigned DEPTH = 27;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned NP    = 2;
    localparam int unsigned LEN_W = 5;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [NP-1:0]               sym_valid;
    logic [NP-1:0][LEN_W-1:0]    sym_len;
    logic                        sym_last;
    logic                        sym_ready;
    logic [DEPTH:1]              arr_preload_en;
    logic [WIDTH-1:0]            arr_preload_data;
    logic [NP-1:0][DEPTH:1]      arr_inc_onehot;
    logic [DEPTH:1][WIDTH-1:0]   arr_count = '0;
    logic                        fc_valid;
    logic [LEN_W-1:0]            fc_len;
    logic [DEPTH-1:0]            fc_code;
    logic [WIDTH-1:0]            fc_count;
    logic                        done;
    logic                        oversub;
    logic                        incomplete;
    logic                        len_err;
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
    logic [LEN_W-1:0]            max_len_o;
`endif

    int unsigned ncmp = 0;
    int unsigned nerr = 0;
    int unsigned exp_cnt [1:DEPTH];

    cr_xp10_decomp_htf_bl_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_PORTS(NP), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sym_valid(sym_valid), .sym_len(sym_len), .sym_last(sym_last),
        .sym_ready(sym_ready),
        .arr_preload_en(arr_preload_en), .arr_preload_data(arr_preload_data),
        .arr_inc_onehot(arr_inc_onehot), .arr_count(arr_count),
        .fc_valid(fc_valid), .fc_len(fc_len), .fc_code(fc_code), .fc_count(fc_count),
        .done(done), .oversub(oversub), .incomplete(incomplete), .len_err(len_err)
`ifdef CR_XP10_DECOMP_HTF_BL_CTRL_MAXLEN_EN
       ,.max_len_o(max_len_o)
`endif
    );

    always #5 clk = ~clk;

    // counter bank: preload wins, otherwise add every port's one-hot bit
    always @(posedge clk) begin
        for (int d = 1; d <= int'(DEPTH); d++) begin
            if (arr_preload_en[d])
                arr_count[d] <= arr_preload_data;
            else
                arr_count[d] <= arr_count[d] + WIDTH'(arr_inc_onehot[0][d])
                                             + WIDTH'(arr_inc_onehot[1][d]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DEPTH:1] oh(input int l);
        logic [DEPTH:1] v;
        v = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " sym_ready"}, 64'(sym_ready), 0);
        chk({tag, " preload_en"}, 64'(arr_preload_en), 0);
        chk({tag, " preload_data"}, 64'(arr_preload_data), 0);
        chk({tag, " inc_onehot"}, 64'(arr_inc_onehot), 0);
        chk({tag, " fc_valid"}, 64'(fc_valid), 0);
        chk({tag, " fc_len"}, 64'(fc_len), 0);
        chk({tag, " fc_code"}, 64'(fc_code), 0);
        chk({tag, " fc_count"}, 64'(fc_count), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " oversub"}, 64'(oversub), 0);
        chk({tag, " incomplete"}, 64'(incomplete), 0);
        chk({tag, " len_err"}, 64'(len_err), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clear preload_en", 64'(arr_preload_en), 64'({DEPTH{1'b1}}));
        chk("clear preload_data", 64'(arr_preload_data), 0);
        chk("clear sym_ready", 64'(sym_ready), 0);
        chk("clear flags", 64'({oversub, incomplete, len_err, done}), 0);
        @(negedge clk);
        chk("accum sym_ready", 64'(sym_ready), 1);
        chk("accum preload_en", 64'(arr_preload_en), 0);
        for (int d = 1; d <= int'(DEPTH); d++) exp_cnt[d] = 0;
    endtask

    task automatic beat(input logic [1:0] v, input logic [4:0] l0, input logic [4:0] l1,
                        input logic last, input logic [DEPTH:1] e0, input logic [DEPTH:1] e1);
        sym_valid  = v;
        sym_len[0] = l0;
        sym_len[1] = l1;
        sym_last   = last;
        #1;
        chk("inc_onehot p0", 64'(arr_inc_onehot[0]), 64'(e0));
        chk("inc_onehot p1", 64'(arr_inc_onehot[1]), 64'(e1));
        @(negedge clk);
        sym_valid = '0;
        sym_last  = 1'b0;
    endtask

    // entered at the DRAIN cycle; h1..h4 are hand-computed first codes for k=1..4
    task automatic run_scan(input logic [DEPTH-1:0] h1, input logic [DEPTH-1:0] h2,
                            input logic [DEPTH-1:0] h3, input logic [DEPTH-1:0] h4,
                            input logic eos, input logic einc);
        logic [63:0] c;
        logic [DEPTH-1:0] hv [1:4];
        hv[1] = h1; hv[2] = h2; hv[3] = h3; hv[4] = h4;
        chk("drain fc_valid", 64'(fc_valid), 0);
        c = 0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            if (k > 1) c = (c + 64'(exp_cnt[k-1])) << 1;
            @(negedge clk);
            chk($sformatf("fc_valid k%0d", k), 64'(fc_valid), 1);
            chk($sformatf("fc_len k%0d", k), 64'(fc_len), 64'(k));
            chk($sformatf("fc_count k%0d", k), 64'(fc_count), 64'(exp_cnt[k]));
            chk($sformatf("fc_code k%0d", k), 64'(fc_code), 64'(c[DEPTH-1:0]));
            chk($sformatf("done early k%0d", k), 64'(done), 0);
            if (k <= 4) chk($sformatf("fc_code hand k%0d", k), 64'(fc_code), 64'(hv[k]));
        end
        @(negedge clk);
        chk("done pulse", 64'(done), 1);
        chk("done oversub", 64'(oversub), 64'(eos));
        chk("done incomplete", 64'(incomplete), 64'(einc));
        chk("done fc_valid", 64'(fc_valid), 0);
        @(negedge clk);
        chk("done one cycle", 64'(done), 0);
        chk("oversub held", 64'(oversub), 64'(eos));
        chk("incomplete held", 64'(incomplete), 64'(einc));
    endtask

    initial begin
        logic seen_done;
        rst = 1'b1; start = 1'b0; sym_valid = '0; sym_len = '0; sym_last = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // lengths {1,2,3,3}: complete tree
        do_start();
        beat(2'b11, 5'd1, 5'd2, 1'b0, oh(1), oh(2));
        beat(2'b11, 5'd3, 5'd3, 1'b1, oh(3), oh(3));
        exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 2;
        run_scan(27'd0, 27'd2, 27'd6, 27'd16, 1'b0, 1'b0);

        // lengths {1,1,1}: oversubscribed
        do_start();
        beat(2'b11, 5'd1, 5'd1, 1'b0, oh(1), oh(1));
        beat(2'b01, 5'd1, 5'd0, 1'b1, oh(1), '0);
        exp_cnt[1] = 3;
        run_scan(27'd0, 27'd6, 27'd12, 27'd24, 1'b1, 1'b0);

        // abort mid-ACCUM with an error pending, then lengths {1}: incomplete
        do_start();
        beat(2'b11, 5'd2, 5'd2, 1'b0, oh(2), oh(2));
        beat(2'b01, 5'd28, 5'd0, 1'b0, '0, '0);
        chk("abort len_err before", 64'(len_err), 1);
        beat(2'b01, 5'd3, 5'd0, 1'b0, oh(3), '0);
        do_start();
        beat(2'b01, 5'd1, 5'd0, 1'b1, oh(1), '0);
        exp_cnt[1] = 1;
        run_scan(27'd0, 27'd2, 27'd4, 27'd8, 1'b0, 1'b1);

        // both ports length 5 for four beats
        do_start();
        for (int b = 0; b < 4; b++)
            beat(2'b11, 5'd5, 5'd5, (b == 3), oh(5), oh(5));
        exp_cnt[5] = 8;
        run_scan(27'd0, 27'd0, 27'd0, 27'd0, 1'b0, 1'b1);

        // length 0 and out-of-range 28: no increments, sticky len_err, empty table
        do_start();
        beat(2'b01, 5'd28, 5'd0, 1'b0, '0, '0);
        chk("len_err set", 64'(len_err), 1);
        beat(2'b11, 5'd0, 5'd0, 1'b1, '0, '0);
        chk("len_err sticky", 64'(len_err), 1);
        run_scan(27'd0, 27'd0, 27'd0, 27'd0, 1'b0, 1'b0);
        chk("len_err after done", 64'(len_err), 1);

        // reset during SCAN
        do_start();
        beat(2'b01, 5'd1, 5'd0, 1'b1, oh(1), '0);
        repeat (3) @(negedge clk);
        chk("scan before rst", 64'(fc_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst in scan");
        seen_done = 1'b0;
        repeat (DEPTH + 4) begin
            @(negedge clk);
            seen_done = seen_done | done | fc_valid;
        end
        chk("no done after rst", 64'(seen_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
